// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream input and instruction-memory write bus of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_data;
    logic              im_wr;

    // The loader consumes the stream and drives the memory write port.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output im_addr,
        output im_data,
        output im_wr
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  im_addr,
        input  im_data,
        input  im_wr
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Frames a byte stream into 16-bit words and writes them into
//               instruction memory, holding the CPU in reset while loading.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        start,
    program_loader_if.slave  bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [5:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam logic [7:0]        c_DEPTH_BYTE = 8'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
    localparam logic [5:0]        c_WORD_ONE   = 6'd1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [7:0]          r_high;
    logic [7:0]          w_high_nxt;
    logic [7:0]          r_csum;
    logic [7:0]          w_csum_nxt;
    logic [5:0]          r_count;
    logic [5:0]          w_count_nxt;
    logic [5:0]          r_words;
    logic [5:0]          w_words_nxt;
    logic                r_hold;
    logic                w_hold_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_error;
    logic                w_error_nxt;

    logic                w_ready;
    logic                w_xfer;
    logic [5:0]          w_words_inc;

    assign w_ready     = (r_state == S_COUNT) || (r_state == S_HI) ||
                         (r_state == S_LO)    || (r_state == S_CSUM);
    assign w_xfer      = w_ready && bus.in_valid;
    assign w_words_inc = r_words + c_WORD_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_high  <= '0;
            r_csum  <= '0;
            r_count <= '0;
            r_words <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_high  <= w_high_nxt;
            r_csum  <= w_csum_nxt;
            r_count <= w_count_nxt;
            r_words <= w_words_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_high_nxt  = r_high;
        w_csum_nxt  = r_csum;
        w_count_nxt = r_count;
        w_words_nxt = r_words;
        w_hold_nxt  = r_hold;
        w_done_nxt  = r_done;
        w_error_nxt = r_error;

        unique case (r_state)
            // A finished or failed load restarts exactly like a fresh one.
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_COUNT;
                    w_hold_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_error_nxt = 1'b0;
                    w_words_nxt = '0;
                    w_csum_nxt  = '0;
                    w_addr_nxt  = '0;
                end
            end
            S_COUNT: begin
                if (w_xfer) begin
                    w_count_nxt = bus.in_data[5:0];
                    if ((bus.in_data == 8'd0) || (bus.in_data > c_DEPTH_BYTE)) begin
                        w_state_nxt = S_ERR;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_HI;
                    end
                end
            end
            S_HI: begin
                if (w_xfer) begin
                    w_high_nxt  = bus.in_data;
                    w_csum_nxt  = r_csum ^ bus.in_data;
                    w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                if (w_xfer) begin
                    w_data_nxt  = {r_high, bus.in_data};
                    w_csum_nxt  = r_csum ^ bus.in_data;
                    w_state_nxt = S_WRITE;
                end
            end
            // Address only advances when another word follows, so it never wraps.
            S_WRITE: begin
                w_words_nxt = w_words_inc;
                if (w_words_inc == r_count) begin
                    w_state_nxt = S_CSUM;
                end else begin
                    w_addr_nxt  = r_addr + c_ADDR_ONE;
                    w_state_nxt = S_HI;
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    if (bus.in_data == r_csum) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_hold_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_error_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready = w_ready;
    assign bus.im_addr  = r_addr;
    assign bus.im_data  = r_data;
    assign bus.im_wr    = (r_state == S_WRITE);
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: receives a byte stream, assembles 16-bit instruction words, and writes them sequentially into the 32-word instruction memory from address 0.
- Holds the processor in reset (cpu_hold) while loading.
- Frames each load with a word-count header and an XOR checksum trailer; reports done or error.

Parameters:
- ADDR_W, 5, instruction memory address width.
- DEPTH, 32, maximum words per load; must equal 2**ADDR_W.
- DATA_W, 16, instruction word width; fixed at two bytes.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs on an edge where in_valid && in_ready.
- im_addr  output  ADDR_W  instruction memory write address.
- im_data  output  DATA_W  instruction memory write data.
- im_wr  output  1  instruction memory write enable, one cycle per word.
- cpu_hold  output  1  drives processor reset while loading.
- done  output  1  sticky; load completed with good checksum.
- error  output  1  sticky; bad count or checksum mismatch.
- words_loaded  output  6  count of words written in the current load.

Behaviour:
- Reset values: state IDLE; in_ready, im_wr, cpu_hold, done, error = 0; im_addr, im_data, words_loaded, checksum, internal count = 0.
- Reset applied mid-load aborts immediately to the reset values. Memory contents written so far are left as-is.
- IDLE: in_ready=0.
  - start=1 -> COUNT.
  - On the same edge: cpu_hold<=1, done<=0, error<=0, words_loaded<=0, checksum<=0, im_addr<=0.
- COUNT: in_ready=1. On transfer, N=in_data.
  - N in 1..DEPTH -> HI.
  - N=0 or N>DEPTH -> ERR.
- HI: in_ready=1. On transfer: high byte latched, checksum^=byte -> LO.
- LO: in_ready=1. On transfer: im_data<={high,byte}, checksum^=byte -> WRITE.
- WRITE: in_ready=0; im_wr=1 for exactly this cycle with im_addr/im_data stable.
  - Exit edge: words_loaded+=1.
  - If words_loaded+1==N -> CSUM; otherwise im_addr+=1 -> HI.
  - im_addr never wraps: N<=DEPTH guarantees the last write is at address N-1.
- CSUM: in_ready=1. On transfer:
  - byte==checksum -> DONE.
  - Otherwise -> ERR.
- DONE: done=1, cpu_hold<=0, in_ready=0.
- ERR: error=1, cpu_hold stays 1 so the processor is not released on a bad image; in_ready=0.
- Restart:
  - From DONE or ERR, start=1 restarts exactly as from IDLE.
  - start is ignored in COUNT/HI/LO/WRITE/CSUM.
- Timing and throughput:
  - Peak throughput is 2 bytes per 3 cycles.
  - in_valid with in_ready=0 is held by the source; no byte is dropped or duplicated.
  - in_valid low stalls any state indefinitely with no timeout.
- State indication: exactly one of done/error is set after a completed or aborted load; never both.
- Checksum definition: XOR of all 2N data bytes. The count byte is excluded.

Test Plan:
- Nominal load: start; bytes 02,12,34,AB,CD,40 -> im_wr pulses at addr0 data 0x1234 and addr1 data 0xABCD; then done=1, cpu_hold=0, words_loaded=2, error=0.
- Bad checksum: same stream with trailer 41 -> error=1, done=0, cpu_hold=1, two writes still performed; a following start plus a valid stream -> done=1, error=0.
- Count boundaries:
  - Count 00 -> ERR with no writes.
  - Count 21 (33) -> ERR.
  - Count 20 (32) with 64 bytes 00..3F and correct XOR trailer -> 32 writes at addr 0..31, last data 0x3E3F, done=1.
- Handshake stalls: insert random in_valid gaps and hold in_valid high through WRITE cycles -> write sequence identical to the nominal case; in_ready=0 every cycle im_wr=1.
- Reset mid-load: assert reset after the first word is written -> next edge all outputs at reset values, state IDLE, cpu_hold=0; a subsequent full load succeeds.
- Ignored start: pulse start during HI -> no restart, im_addr/checksum unaffected, load completes done=1.
